red_pitaya_pwm_dac: RTL and testbench

Four-channel PWM DAC generator driving the slow analog outputs. It consumes the four 24-bit PWM DAC words produced by the analog mixed-signal register block: 8-bit duty plus a 16-bit dither sequence per channel. It turns each word into a single-bit PWM stream for the external RC filters. Configuration words are sampled only at frame boundaries, so software writes never cause mid-period glitches.

---
 rtl/red_pitaya_pwm_dac_if.sv | 20 ++
 rtl/red_pitaya_pwm_dac.sv | 102 ++++++++++
 tb/tb_red_pitaya_pwm_dac.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/red_pitaya_pwm_dac_if.sv
// Configuration/output bundle of the four-channel PWM DAC.
// master drives the 24-bit channel words, slave returns PWM bits and the frame pulse.
interface red_pitaya_pwm_dac_if;
  logic [23:0] cfg_a_i;
  logic [23:0] cfg_b_i;
  logic [23:0] cfg_c_i;
  logic [23:0] cfg_d_i;
  logic [3:0]  pwm_o;
  logic        frame_o;

  modport master (
    output cfg_a_i, cfg_b_i, cfg_c_i, cfg_d_i,
    input  pwm_o, frame_o
  );

  modport slave (
    input  cfg_a_i, cfg_b_i, cfg_c_i, cfg_d_i,
    output pwm_o, frame_o
  );
endinterface

// File: rtl/red_pitaya_pwm_dac.sv
// Four-channel PWM DAC with 16-period dithered frames and frame-aligned config shadows.
// Optional macro PWM_DITHER_EN: when defined, bit bcnt of the 16-bit dither field is added to the duty.

module pwm_dac_lane #(
  parameter int VEC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic [7:0]       vcnt,
  input  logic [3:0]       bcnt,
  input  logic [VEC_W-1:0] cfg,
  output logic             pwm
);
  logic [8:0] thr;

`ifdef PWM_DITHER_EN
  logic [VEC_W-1:0] shadow;
  logic [VEC_W-1:0] eff;

  always_ff @(posedge clk) begin
    if (rst)              shadow <= '0;
    else if (frame_start) shadow <= cfg;
  end

  // the new word is live in the very cycle it is captured
  assign eff = frame_start ? cfg : shadow;
  assign thr = {1'b0, eff[23:16]} + {8'd0, eff[bcnt]};
`else
  logic [7:0] shadow;
  logic [7:0] eff;
  logic       unused_dither;

  always_ff @(posedge clk) begin
    if (rst)              shadow <= '0;
    else if (frame_start) shadow <= cfg[23:16];
  end

  assign eff           = frame_start ? cfg[23:16] : shadow;
  assign thr           = {1'b0, eff};
  assign unused_dither = ^{cfg[15:0], bcnt};
`endif

  // 9-bit compare: thr=256 stays above any vcnt instead of wrapping to 0
  always_ff @(posedge clk) begin
    if (rst) pwm <= 1'b0;
    else     pwm <= ({1'b0, vcnt} < thr);
  end
endmodule

module red_pitaya_pwm_dac #(
  parameter int CCRE = 156
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  red_pitaya_pwm_dac_if.slave  bus
);
  localparam int         NUM_LANES = 4;
  localparam int         VEC_W     = 24;
  localparam logic [7:0] VMAX      = 8'(CCRE - 1);

  logic [7:0]                        vcnt;
  logic [3:0]                        bcnt;
  logic                              frame_start;
  logic                              frame_q;
  logic [NUM_LANES-1:0][VEC_W-1:0]   cfg;
  logic [NUM_LANES-1:0]              pwm;

  assign cfg         = {bus.cfg_d_i, bus.cfg_c_i, bus.cfg_b_i, bus.cfg_a_i};
  assign frame_start = (vcnt == 8'd0) && (bcnt == 4'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vcnt    <= '0;
      bcnt    <= '0;
      frame_q <= 1'b0;
    end else begin
      frame_q <= frame_start;
      if (vcnt == VMAX) begin
        vcnt <= '0;
        bcnt <= bcnt + 4'd1;
      end else begin
        vcnt <= vcnt + 8'd1;
      end
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    pwm_dac_lane #(.VEC_W(VEC_W)) u_lane (
      .clk         (clk_i),
      .rst         (rst_i),
      .frame_start (frame_start),
      .vcnt        (vcnt),
      .bcnt        (bcnt),
      .cfg         (cfg[l]),
      .pwm         (pwm[l])
    );
  end

  assign bus.pwm_o   = pwm;
  assign bus.frame_o = frame_q;
endmodule

// File: tb/tb_red_pitaya_pwm_dac.sv
// Scoreboard bench: per-period high-cycle counts are queued when configs are driven
// and popped as each output period completes.
module tb_red_pitaya_pwm_dac;
  localparam int CCRE  = 156;
  localparam int FRAME = 16 * CCRE;

  typedef logic [3:0][23:0] cfg4_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  red_pitaya_pwm_dac_if bus();

  red_pitaya_pwm_dac #(.CCRE(CCRE)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive_cfg(input cfg4_t c);
    bus.cfg_a_i = c[0];
    bus.cfg_b_i = c[1];
    bus.cfg_c_i = c[2];
    bus.cfg_d_i = c[3];
  endtask

  function automatic int dith(input logic [23:0] w, input int k);
`ifdef PWM_DITHER_EN
    return int'(w[k]);
`else
    return 0;
`endif
  endfunction

  // expected high cycles for each period/channel of one frame: min(V+B[k], CCRE)
  task automatic push_frame(input cfg4_t c);
    for (int k = 0; k < 16; k++)
      for (int ch = 0; ch < 4; ch++) begin
        int t;
        t = int'(c[ch][23:16]) + dith(c[ch], k);
        exp_q.push_back(t > CCRE ? CCRE : t);
      end
  endtask

  // Entered at the sample where frame_o should be high; leaves at the next frame's first sample.
  task automatic run_frame(input int chg_pos, input int rst_pos, input cfg4_t nxt);
    int hi[4];
    int shape[4];
    bit seen_low[4];
    int stray;
    stray = 0;
    for (int ch = 0; ch < 4; ch++) begin
      hi[ch] = 0; shape[ch] = 0; seen_low[ch] = 0;
    end
    for (int p = 0; p < FRAME; p++) begin
      if (p == 0) chk("frame_o_start", int'(bus.frame_o), 1);
      else if (bus.frame_o) stray++;
      if (p % CCRE == 0)
        for (int ch = 0; ch < 4; ch++) begin
          hi[ch] = 0; seen_low[ch] = 0;
        end
      for (int ch = 0; ch < 4; ch++) begin
        if (bus.pwm_o[ch]) begin
          hi[ch]++;
          if (seen_low[ch]) shape[ch]++;
        end else begin
          seen_low[ch] = 1'b1;
        end
      end
      if (p % CCRE == CCRE - 1)
        for (int ch = 0; ch < 4; ch++) begin
          int e;
          e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
          chk($sformatf("period%0d_ch%0d_high", p / CCRE, ch), hi[ch], e);
        end
      if (p == chg_pos) begin
        drive_cfg(nxt);
        push_frame(nxt);
      end
      if (p == rst_pos) begin
        drive_cfg(nxt);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_pwm", int'(bus.pwm_o), 0);
        chk("midrst_frame", int'(bus.frame_o), 0);
        rst = 1'b0;
        exp_q.delete();
        push_frame(nxt);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    chk("frame_o_stray", stray, 0);
    for (int ch = 0; ch < 4; ch++) chk($sformatf("shape_ch%0d", ch), shape[ch], 0);
  endtask

  cfg4_t f0, f1, f2, r1, r2, f5, r6;

  initial begin
    f0 = {24'h10_0000, 24'hFF_FFFF, 24'h0F_0005, 24'h4E_0000};
    f1 = {24'h80_0000, 24'h00_0000, 24'h0F_0005, 24'h4E_0000};
    f2 = {24'h9B_0001, 24'h9C_0000, 24'hFF_FFFF, 24'h00_0000};
    r1 = {24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom)};
    r2 = {24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom)};
    f5 = {24'h33_F0F0, 24'h01_8001, 24'h9A_FFFF, 24'h20_ABCD};
    r6 = {24'h07_1234, 24'h60_0F0F, 24'hC8_5555, 24'h00_FFFF};

    drive_cfg(f0);
    push_frame(f0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_pwm", int'(bus.pwm_o), 0);
      chk("rst_frame", int'(bus.frame_o), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    run_frame(7 * CCRE + 39, -1, f1);   // mid-frame update must not touch this frame
    run_frame(100, -1, f2);
    run_frame(FRAME - 1, -1, r1);       // change in the frame-start cycle is taken
    run_frame(0, -1, r2);               // change one cycle late waits a frame
    run_frame(500, -1, f5);
    run_frame(-1, 9 * CCRE + 99, r6);   // reset at bcnt=9, vcnt=100
    run_frame(-1, -1, r6);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
